// File: rtl/ic_rgbtoycbcr_out_scheduler_if.sv
// Bundle of the scheduler's control, FIFO-side and downstream-side signals.
// master = the scheduler, slave = the FIFOs / downstream / controlling environment.
interface ic_rgbtoycbcr_out_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             ffY_empty;
  logic             ffCb_empty;
  logic             ffCr_empty;
  logic [63:0]      ffY_q;
  logic [63:0]      ffCb_q;
  logic [63:0]      ffCr_q;
  logic             ffY_readrequest;
  logic             ffCb_readrequest;
  logic             ffCr_readrequest;
  logic [63:0]      R2Y_writedata;
  logic             R2Y_outputready;
  logic             R2Y_waitrequest_ds;
  logic [1:0]       comp_tag;
  logic             blk_done;
  logic [CNT_W-1:0] blk_count;

  modport master (
    input  enable, ffY_empty, ffCb_empty, ffCr_empty,
    input  ffY_q, ffCb_q, ffCr_q, R2Y_waitrequest_ds,
    output ffY_readrequest, ffCb_readrequest, ffCr_readrequest,
    output R2Y_writedata, R2Y_outputready, comp_tag, blk_done, blk_count
  );

  modport slave (
    output enable, ffY_empty, ffCb_empty, ffCr_empty,
    output ffY_q, ffCb_q, ffCr_q, R2Y_waitrequest_ds,
    input  ffY_readrequest, ffCb_readrequest, ffCr_readrequest,
    input  R2Y_writedata, R2Y_outputready, comp_tag, blk_done, blk_count
  );
endinterface

// File: rtl/ic_rgbtoycbcr_out_scheduler.sv
// Output scheduler for the RGB->YCbCr converter: drains one 8x8 block as
// BLK_WORDS Y, then Cb, then Cr words from three component FIFOs into a single
// 64-bit stream, through a credit-controlled 2-entry in-order output buffer.
module ic_rgbtoycbcr_out_scheduler #(
  parameter int BLK_WORDS = 8,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  ic_rgbtoycbcr_out_scheduler_if.master bus
);

  localparam int RC_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam int OC_W = $clog2(3 * BLK_WORDS);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(BLK_WORDS - 1);
  localparam logic [OC_W-1:0] OC_LAST = OC_W'(3 * BLK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RD_Y, RD_CB, RD_CR} state_t;
  typedef enum logic [1:0] {TAG_Y = 2'd0, TAG_CB = 2'd1, TAG_CR = 2'd2} tag_t;

  state_t           r_state;
  logic [RC_W-1:0]  r_rd_cnt;
  logic [OC_W-1:0]  r_out_cnt;
  logic             r_inflight;
  tag_t             r_inflight_tag;
  logic [63:0]      r_buf_data [2];
  tag_t             r_buf_tag  [2];
  logic [1:0]       r_buf_cnt;
  logic [CNT_W-1:0] r_blk_count;

  logic             w_xfer;
  logic [1:0]       w_occ_net;
  logic             w_credit;
  logic             w_rd_y;
  logic             w_rd_cb;
  logic             w_rd_cr;
  logic             w_rd;
  tag_t             w_rd_tag;
  state_t           w_next_state;
  logic             w_push_idx;
  logic [63:0]      w_cap_data;
  logic             w_blk_last;

  // A word leaves when the head is valid and downstream is not stalling.
  assign w_xfer    = (r_buf_cnt != 2'd0) && !bus.R2Y_waitrequest_ds;
  // Entries that will still be held or owed after this cycle's transfer.
  assign w_occ_net = r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_xfer};
  assign w_credit  = (w_occ_net < 2'd2);

  // NOTE: read strobes are decoded combinationally from the current empty flag;
  // a registered strobe would act on last cycle's flag and could pop an empty FIFO.
  assign w_rd_y  = !reset && (r_state == RD_Y)  && !bus.ffY_empty  && w_credit;
  assign w_rd_cb = !reset && (r_state == RD_CB) && !bus.ffCb_empty && w_credit;
  assign w_rd_cr = !reset && (r_state == RD_CR) && !bus.ffCr_empty && w_credit;
  assign w_rd    = w_rd_y || w_rd_cb || w_rd_cr;
  assign w_rd_tag = w_rd_cb ? TAG_CB : (w_rd_cr ? TAG_CR : TAG_Y);

  // Slot that returning data lands in: count after this cycle's pop (0 or 1).
  assign w_push_idx = r_buf_cnt[0] ^ w_xfer;

  assign w_blk_last = w_xfer && (r_out_cnt == OC_LAST);

  assign bus.ffY_readrequest  = w_rd_y;
  assign bus.ffCb_readrequest = w_rd_cb;
  assign bus.ffCr_readrequest = w_rd_cr;
  assign bus.R2Y_writedata    = r_buf_data[0];
  assign bus.comp_tag         = r_buf_tag[0];
  assign bus.R2Y_outputready  = (r_buf_cnt != 2'd0);
  assign bus.blk_done         = w_blk_last;
  assign bus.blk_count        = r_blk_count;

  // Component order within a block: Y -> Cb -> Cr -> back to idle.
  always_comb begin
    w_next_state = IDLE;
    case (r_state)
      RD_Y:    w_next_state = RD_CB;
      RD_CB:   w_next_state = RD_CR;
      default: w_next_state = IDLE;
    endcase
  end

  // Select the FIFO whose read returns this cycle.
  always_comb begin
    w_cap_data = bus.ffY_q;
    case (r_inflight_tag)
      TAG_CB:  w_cap_data = bus.ffCb_q;
      TAG_CR:  w_cap_data = bus.ffCr_q;
      default: w_cap_data = bus.ffY_q;
    endcase
  end

  // Block sequencer: start on enable, advance after BLK_WORDS issued reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_rd_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.enable) r_state <= RD_Y;
        default: begin
          if (w_rd) begin
            if (r_rd_cnt == RC_LAST) begin
              r_rd_cnt <= '0;
              r_state  <= w_next_state;
            end else begin
              r_rd_cnt <= r_rd_cnt + RC_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Read pipeline, output buffer and block accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight     <= 1'b0;
      r_inflight_tag <= TAG_Y;
      r_buf_cnt      <= 2'd0;
      // NOTE: the two buffer slots are reset because slot 0 drives the visible
      // output word, which must read as zero out of reset.
      r_buf_data[0]  <= '0;
      r_buf_data[1]  <= '0;
      r_buf_tag[0]   <= TAG_Y;
      r_buf_tag[1]   <= TAG_Y;
      r_out_cnt      <= '0;
      r_blk_count    <= '0;
    end else begin
      r_inflight <= w_rd;
      if (w_rd) r_inflight_tag <= w_rd_tag;

      if (w_xfer) begin
        r_buf_data[0] <= r_buf_data[1];
        r_buf_tag[0]  <= r_buf_tag[1];
      end
      // NOTE: this write comes after the shift on purpose; when both target
      // slot 0, the later non-blocking assignment (the new word) wins.
      if (r_inflight) begin
        r_buf_data[w_push_idx] <= w_cap_data;
        r_buf_tag[w_push_idx]  <= r_inflight_tag;
      end
      r_buf_cnt <= r_buf_cnt - {1'b0, w_xfer} + {1'b0, r_inflight};

      if (w_xfer) r_out_cnt <= (r_out_cnt == OC_LAST) ? '0 : r_out_cnt + OC_W'(1);
      if (w_blk_last) r_blk_count <= r_blk_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ic_rgbtoycbcr_out_scheduler.sv
// Directed bench for ic_rgbtoycbcr_out_scheduler: FIFO models feed tagged
// words, a monitor logs transfers and reads, and each scenario task checks
// the logged stream against hand-derived expectations.
module tb_ic_rgbtoycbcr_out_scheduler;

  localparam int BLK_WORDS = 8;
  localparam int CNT_W     = 4;
  localparam int WPB       = 3 * BLK_WORDS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ic_rgbtoycbcr_out_scheduler_if #(.CNT_W(CNT_W)) bus ();

  ic_rgbtoycbcr_out_scheduler #(.BLK_WORDS(BLK_WORDS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  // FIFO models
  logic [63:0] mem_y [256];
  logic [63:0] mem_cb [256];
  logic [63:0] mem_cr [256];
  logic [7:0]  wp_y = 8'd0, wp_cb = 8'd0, wp_cr = 8'd0;
  logic [7:0]  rp_y = 8'd0, rp_cb = 8'd0, rp_cr = 8'd0;
  logic        hold_cb = 1'b0;
  logic        mon_clr = 1'b0;

  assign bus.ffY_empty  = (wp_y == rp_y);
  assign bus.ffCb_empty = (wp_cb == rp_cb) || hold_cb;
  assign bus.ffCr_empty = (wp_cr == rp_cr);

  always @(posedge clk) begin
    if (reset) begin
      rp_y <= 8'd0; rp_cb <= 8'd0; rp_cr <= 8'd0;
    end else begin
      if (bus.ffY_readrequest)  begin bus.ffY_q  <= mem_y[rp_y];   rp_y  <= rp_y + 8'd1;  end
      if (bus.ffCb_readrequest) begin bus.ffCb_q <= mem_cb[rp_cb]; rp_cb <= rp_cb + 8'd1; end
      if (bus.ffCr_readrequest) begin bus.ffCr_q <= mem_cr[rp_cr]; rp_cr <= rp_cr + 8'd1; end
    end
  end

  // Monitor
  int          cyc = 0;
  int          n_obs, n_rd_y, n_rd_cb, n_rd_cr, n_done, bad_done, multi_rd, rd_empty, done_cyc;
  logic [CNT_W-1:0] last_pre_cnt;
  logic [63:0] obs_data [512];
  logic [1:0]  obs_tag  [512];
  int          obs_cyc  [512];
  int          rd_cyc_y [256];
  int          rd_cyc_cr[256];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || mon_clr) begin
      n_obs <= 0; n_rd_y <= 0; n_rd_cb <= 0; n_rd_cr <= 0; n_done <= 0;
      bad_done <= 0; multi_rd <= 0; rd_empty <= 0; done_cyc <= -1; last_pre_cnt <= '0;
    end else begin
      if (bus.R2Y_outputready && !bus.R2Y_waitrequest_ds && n_obs < 512) begin
        obs_data[n_obs[8:0]] <= bus.R2Y_writedata;
        obs_tag[n_obs[8:0]]  <= bus.comp_tag;
        obs_cyc[n_obs[8:0]]  <= cyc;
        n_obs <= n_obs + 1;
      end
      if (bus.blk_done) begin
        n_done <= n_done + 1;
        done_cyc <= cyc;
        last_pre_cnt <= bus.blk_count;
        if (!(bus.R2Y_outputready && !bus.R2Y_waitrequest_ds)) bad_done <= bad_done + 1;
      end
      if (int'(bus.ffY_readrequest) + int'(bus.ffCb_readrequest) + int'(bus.ffCr_readrequest) > 1)
        multi_rd <= multi_rd + 1;
      if ((bus.ffY_readrequest && bus.ffY_empty) || (bus.ffCb_readrequest && bus.ffCb_empty) ||
          (bus.ffCr_readrequest && bus.ffCr_empty))
        rd_empty <= rd_empty + 1;
      if (bus.ffY_readrequest) begin rd_cyc_y[n_rd_y[7:0]] <= cyc; n_rd_y <= n_rd_y + 1; end
      if (bus.ffCb_readrequest) n_rd_cb <= n_rd_cb + 1;
      if (bus.ffCr_readrequest) begin rd_cyc_cr[n_rd_cr[7:0]] <= cyc; n_rd_cr <= n_rd_cr + 1; end
    end
  end

  function automatic logic [63:0] word(input int c, input int b, input int i);
    logic [7:0] pfx;
    pfx = (c == 0) ? 8'h11 : ((c == 1) ? 8'h22 : 8'h33);
    return {pfx, 24'h0, 16'(b), 16'(i)};
  endfunction

  // Counts words of the logged stream that differ from block-ordered Y/Cb/Cr data.
  function automatic int stream_errs(input int n, output int first);
    int errs = 0;
    first = -1;
    for (int k = 0; k < n; k++) begin
      int b, c, i;
      b = k / WPB;
      c = (k % WPB) / BLK_WORDS;
      i = k % BLK_WORDS;
      if (obs_data[k[8:0]] !== word(c, b, i) || obs_tag[k[8:0]] !== 2'(c)) begin
        if (first < 0) first = k;
        errs++;
      end
    end
    return errs;
  endfunction

  task automatic preload(input int base, input int nblk);
    for (int b = base; b < base + nblk; b++)
      for (int i = 0; i < BLK_WORDS; i++) begin
        mem_y[wp_y] = word(0, b, i);   wp_y  = wp_y + 8'd1;
        mem_cb[wp_cb] = word(1, b, i); wp_cb = wp_cb + 8'd1;
        mem_cr[wp_cr] = word(2, b, i); wp_cr = wp_cr + 8'd1;
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.R2Y_waitrequest_ds = 1'b0;
    hold_cb = 1'b0;
    wp_y = 8'd0; wp_cb = 8'd0; wp_cr = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_obs(input int target, input int budget, output bit ok);
    for (int k = 0; k < budget && n_obs < target; k++) @(negedge clk);
    ok = (n_obs >= target);
  endtask

  task automatic wait_rdy(input int target, input int budget, output bit ok);
    for (int k = 0; k < budget && n_rd_y < target; k++) @(negedge clk);
    ok = (n_rd_y >= target);
  endtask

  task automatic test_reset();
    bus.enable = 1'b1;
    bus.R2Y_waitrequest_ds = 1'b0;
    reset = 1'b1;
    preload(0, 1);
    repeat (3) @(negedge clk);
    n_total++; if (bus.R2Y_outputready !== 1'b0) $display("FAIL rst_outputready: got %b expected 0", bus.R2Y_outputready); else n_pass++;
    n_total++; if (bus.R2Y_writedata !== 64'h0) $display("FAIL rst_writedata: got %h expected 0", bus.R2Y_writedata); else n_pass++;
    n_total++; if (bus.comp_tag !== 2'd0) $display("FAIL rst_comp_tag: got %0d expected 0", bus.comp_tag); else n_pass++;
    n_total++; if (bus.blk_done !== 1'b0) $display("FAIL rst_blk_done: got %b expected 0", bus.blk_done); else n_pass++;
    n_total++; if (bus.blk_count !== '0) $display("FAIL rst_blk_count: got %0d expected 0", bus.blk_count); else n_pass++;
    n_total++;
    if ({bus.ffY_readrequest, bus.ffCb_readrequest, bus.ffCr_readrequest} !== 3'b000)
      $display("FAIL rst_readrequest: got %b expected 000", {bus.ffY_readrequest, bus.ffCb_readrequest, bus.ffCr_readrequest});
    else n_pass++;
    bus.enable = 1'b0;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    n_total++; if (n_rd_y + n_rd_cb + n_rd_cr !== 0) $display("FAIL idle_no_read: got %0d reads expected 0", n_rd_y + n_rd_cb + n_rd_cr); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok; int first, errs;
    do_reset();
    preload(0, 1);
    bus.enable = 1'b1;
    wait_obs(24, 100, ok);
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    n_total++; if (!ok) $display("FAIL basic_timeout: got %0d transfers expected 24", n_obs); else n_pass++;
    n_total++; if (n_obs !== 24) $display("FAIL basic_count: got %0d expected 24", n_obs); else n_pass++;
    errs = stream_errs(24, first);
    n_total++; if (errs !== 0) $display("FAIL basic_stream: got %0d bad words (first idx %0d) expected 0", errs, first); else n_pass++;
    n_total++; if (obs_cyc[0] - rd_cyc_y[0] !== 2) $display("FAIL basic_latency: got %0d expected 2", obs_cyc[0] - rd_cyc_y[0]); else n_pass++;
    n_total++; if (obs_cyc[23] - obs_cyc[0] !== 23) $display("FAIL basic_throughput: got %0d expected 23", obs_cyc[23] - obs_cyc[0]); else n_pass++;
    n_total++; if (n_done !== 1) $display("FAIL basic_done_pulses: got %0d expected 1", n_done); else n_pass++;
    n_total++; if (done_cyc !== obs_cyc[23]) $display("FAIL basic_done_cycle: got %0d expected %0d", done_cyc, obs_cyc[23]); else n_pass++;
    n_total++; if (bad_done !== 0) $display("FAIL basic_done_no_xfer: got %0d expected 0", bad_done); else n_pass++;
    n_total++; if (bus.blk_count !== 4'd1) $display("FAIL basic_blk_count: got %0d expected 1", bus.blk_count); else n_pass++;
    n_total++; if (multi_rd + rd_empty !== 0) $display("FAIL basic_read_rules: got %0d violations expected 0", multi_rd + rd_empty); else n_pass++;
  endtask

  task automatic test_stall();
    bit ok; int first, errs, held_bad, max_ahead;
    logic [63:0] ref_data; logic [1:0] ref_tag;
    do_reset();
    preload(0, 1);
    bus.enable = 1'b1;
    wait_obs(2, 50, ok);
    bus.R2Y_waitrequest_ds = 1'b1;
    ref_data = bus.R2Y_writedata;
    ref_tag = bus.comp_tag;
    n_total++; if (!ok || bus.R2Y_outputready !== 1'b1) $display("FAIL stall_start: got ok=%0d ready=%b expected 1/1", ok, bus.R2Y_outputready); else n_pass++;
    n_total++; if (ref_data !== word(0, 0, 2)) $display("FAIL stall_word: got %h expected %h", ref_data, word(0, 0, 2)); else n_pass++;
    held_bad = 0; max_ahead = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.R2Y_writedata !== ref_data || bus.comp_tag !== ref_tag || bus.R2Y_outputready !== 1'b1) held_bad++;
      if (n_rd_y + n_rd_cb + n_rd_cr - n_obs > max_ahead) max_ahead = n_rd_y + n_rd_cb + n_rd_cr - n_obs;
    end
    n_total++; if (held_bad !== 0) $display("FAIL stall_hold: got %0d unstable cycles expected 0", held_bad); else n_pass++;
    n_total++; if (max_ahead > 2) $display("FAIL stall_credit: got %0d reads ahead expected at most 2", max_ahead); else n_pass++;
    bus.R2Y_waitrequest_ds = 1'b0;
    wait_obs(24, 100, ok);
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    n_total++; if (n_obs !== 24) $display("FAIL stall_count: got %0d expected 24", n_obs); else n_pass++;
    errs = stream_errs(24, first);
    n_total++; if (errs !== 0) $display("FAIL stall_stream: got %0d bad words (first idx %0d) expected 0", errs, first); else n_pass++;
  endtask

  task automatic test_gap();
    bit ok; int first, errs;
    do_reset();
    hold_cb = 1'b1;
    preload(0, 1);
    bus.enable = 1'b1;
    wait_rdy(8, 50, ok);
    repeat (10) @(negedge clk);
    n_total++; if (!ok || n_rd_y !== 8) $display("FAIL gap_y_reads: got %0d expected 8", n_rd_y); else n_pass++;
    n_total++; if (n_rd_cb + n_rd_cr !== 0) $display("FAIL gap_no_read: got %0d expected 0", n_rd_cb + n_rd_cr); else n_pass++;
    hold_cb = 1'b0;
    wait_obs(24, 100, ok);
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    n_total++; if (n_obs !== 24) $display("FAIL gap_count: got %0d expected 24", n_obs); else n_pass++;
    errs = stream_errs(24, first);
    n_total++; if (errs !== 0) $display("FAIL gap_stream: got %0d bad words (first idx %0d) expected 0", errs, first); else n_pass++;
    n_total++; if (rd_empty !== 0) $display("FAIL gap_read_empty: got %0d expected 0", rd_empty); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok; int first, errs;
    do_reset();
    preload(0, 2);
    bus.enable = 1'b1;
    wait_obs(48, 200, ok);
    bus.enable = 1'b0;
    repeat (5) @(negedge clk);
    n_total++; if (n_obs !== 48) $display("FAIL b2b_count: got %0d expected 48", n_obs); else n_pass++;
    errs = stream_errs(48, first);
    n_total++; if (errs !== 0) $display("FAIL b2b_stream: got %0d bad words (first idx %0d) expected 0", errs, first); else n_pass++;
    n_total++; if (n_done !== 2) $display("FAIL b2b_done_pulses: got %0d expected 2", n_done); else n_pass++;
    n_total++; if (bus.blk_count !== 4'd2) $display("FAIL b2b_blk_count: got %0d expected 2", bus.blk_count); else n_pass++;
    n_total++; if (rd_cyc_y[8] - rd_cyc_cr[7] !== 2) $display("FAIL b2b_idle_gap: got %0d expected 2", rd_cyc_y[8] - rd_cyc_cr[7]); else n_pass++;
    n_total++; if (obs_cyc[24] - obs_cyc[23] !== 2) $display("FAIL b2b_out_gap: got %0d expected 2", obs_cyc[24] - obs_cyc[23]); else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit ok; int first, errs;
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    preload(0, 1);
    bus.enable = 1'b1;
    wait_obs(13, 60, ok);
    reset = 1'b1;
    wp_y = 8'd0; wp_cb = 8'd0; wp_cr = 8'd0;
    @(negedge clk);
    n_total++; if (!ok) $display("FAIL mrst_reach13: got %0d transfers expected 13", n_obs); else n_pass++;
    n_total++;
    if ({bus.R2Y_outputready, bus.blk_done, bus.comp_tag} !== 4'b0 || bus.R2Y_writedata !== 64'h0)
      $display("FAIL mrst_outputs: got ready=%b done=%b tag=%0d data=%h expected all 0", bus.R2Y_outputready, bus.blk_done, bus.comp_tag, bus.R2Y_writedata);
    else n_pass++;
    n_total++; if (bus.blk_count !== '0) $display("FAIL mrst_blk_count: got %0d expected 0", bus.blk_count); else n_pass++;
    n_total++;
    if ({bus.ffY_readrequest, bus.ffCb_readrequest, bus.ffCr_readrequest} !== 3'b000)
      $display("FAIL mrst_readrequest: got %b expected 000", {bus.ffY_readrequest, bus.ffCb_readrequest, bus.ffCr_readrequest});
    else n_pass++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    preload(0, 1);
    wait_obs(24, 100, ok);
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    n_total++; if (n_obs !== 24) $display("FAIL mrst_count: got %0d expected 24", n_obs); else n_pass++;
    errs = stream_errs(24, first);
    n_total++; if (errs !== 0) $display("FAIL mrst_stream: got %0d bad words (first idx %0d) expected 0", errs, first); else n_pass++;
  endtask

  task automatic test_enable_drop();
    bit ok;
    do_reset();
    preload(0, 2);
    bus.enable = 1'b1;
    wait_rdy(1, 20, ok);
    bus.enable = 1'b0;
    wait_obs(24, 100, ok);
    repeat (10) @(negedge clk);
    n_total++; if (n_obs !== 24) $display("FAIL endrop_count: got %0d expected 24", n_obs); else n_pass++;
    n_total++; if (n_rd_y + n_rd_cb + n_rd_cr !== 24) $display("FAIL endrop_reads: got %0d expected 24", n_rd_y + n_rd_cb + n_rd_cr); else n_pass++;
    n_total++; if (n_done !== 1) $display("FAIL endrop_done: got %0d expected 1", n_done); else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok; int first, errs;
    do_reset();
    preload(0, 16);
    bus.enable = 1'b1;
    wait_obs(16 * WPB, 1500, ok);
    bus.enable = 1'b0;
    repeat (5) @(negedge clk);
    n_total++; if (n_obs !== 16 * WPB) $display("FAIL wrap_count: got %0d expected %0d", n_obs, 16 * WPB); else n_pass++;
    n_total++; if (n_done !== 16) $display("FAIL wrap_done: got %0d expected 16", n_done); else n_pass++;
    n_total++; if (last_pre_cnt !== 4'd15) $display("FAIL wrap_pre: got %0d expected 15", last_pre_cnt); else n_pass++;
    n_total++; if (bus.blk_count !== 4'd0) $display("FAIL wrap_blk_count: got %0d expected 0", bus.blk_count); else n_pass++;
    errs = stream_errs(16 * WPB, first);
    n_total++; if (errs !== 0) $display("FAIL wrap_stream: got %0d bad words (first idx %0d) expected 0", errs, first); else n_pass++;
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.R2Y_waitrequest_ds = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_gap();
    test_back_to_back();
    test_mid_reset();
    test_enable_drop();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
